// File: rtl/interrupt_controller.sv
// External interrupt controller for the pipelined Beta core: synchronizes and edge-detects
// two interrupt lines, latches them as pending, and holds one prioritized request until ACK.
module interrupt_controller #(
    parameter int SYNC_STAGES    = 2,
    parameter int HOLDOFF_CYCLES = 2
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [1:0]  Irq_In,
    input  logic        IO_EnR,
    input  logic        IO_EnW,
    input  logic [31:0] IO_DataW,
    output logic [31:0] IO_DataR,
    output logic        I_Req,
    output logic        I_Id
);

    localparam int CNT_W = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACTIVE  = 2'd1,
        HOLDOFF = 2'd2
    } state_e;

    logic [1:0]       sync_q [SYNC_STAGES];
    logic [1:0]       sync_d [SYNC_STAGES];
    logic [1:0]       hist_q, hist_d;
    logic [1:0]       pend_q, pend_d;
    logic [1:0]       en_q, en_d;
    logic [1:0]       ovf_q, ovf_d;
    state_e           state_q, state_d;
    logic             act_id_q, act_id_d;
    logic             req_q, req_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      data_r_q, data_r_d;

    logic [1:0] rise, set, ack_mask, elig;
    logic [1:0] cmd;
    logic       ack_hit;
    logic       unused_data_bits;

    assign unused_data_bits = ^{IO_DataW[29:6], IO_DataW[3:2]};
    assign cmd = IO_DataW[31:30];

    always_comb begin
        sync_d[0] = Irq_In;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
        hist_d = sync_q[SYNC_STAGES-1];
        rise   = sync_q[SYNC_STAGES-1] & ~hist_q;
    end

    // A matching ACK releases the active source; a simultaneous new rise on it re-pends it
    // without counting as an overflow.
    always_comb begin
        ack_hit  = IO_EnW && (cmd == 2'b10) && (state_q == ACTIVE) && (IO_DataW[0] == act_id_q);
        ack_mask = ack_hit ? (act_id_q ? 2'b10 : 2'b01) : 2'b00;
        set      = rise & en_q;
        elig     = pend_q & en_q;

        pend_d = (pend_q & ~ack_mask) | set;
        ovf_d  = ovf_q;
        if (IO_EnW && (cmd == 2'b11)) begin
            ovf_d = ovf_q & ~IO_DataW[5:4];
        end
        ovf_d = ovf_d | (set & pend_q & ~ack_mask);

        en_d = en_q;
        if (IO_EnW && (cmd == 2'b01)) begin
            en_d = IO_DataW[1:0];
        end

        data_r_d = data_r_q;
        if (IO_EnR) begin
            data_r_d = {24'd0, act_id_q, (state_q == ACTIVE), ovf_q, en_q, pend_q};
        end
    end

    always_comb begin
        state_d  = state_q;
        act_id_d = act_id_q;
        req_d    = req_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: begin
                if (elig != 2'b00) begin
                    act_id_d = ~elig[0];
                    req_d    = 1'b1;
                    state_d  = ACTIVE;
                end
            end
            ACTIVE: begin
                if (ack_hit) begin
                    cnt_d   = CNT_W'(HOLDOFF_CYCLES - 1);
                    req_d   = 1'b0;
                    state_d = HOLDOFF;
                end
            end
            HOLDOFF: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                req_d   = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= 2'b00;
            end
            hist_q   <= 2'b00;
            pend_q   <= 2'b00;
            en_q     <= 2'b00;
            ovf_q    <= 2'b00;
            state_q  <= IDLE;
            act_id_q <= 1'b0;
            req_q    <= 1'b0;
            cnt_q    <= '0;
            data_r_q <= 32'd0;
        end else begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_d[i];
            end
            hist_q   <= hist_d;
            pend_q   <= pend_d;
            en_q     <= en_d;
            ovf_q    <= ovf_d;
            state_q  <= state_d;
            act_id_q <= act_id_d;
            req_q    <= req_d;
            cnt_q    <= cnt_d;
            data_r_q <= data_r_d;
        end
    end

    assign IO_DataR = data_r_q;
    assign I_Req    = req_q;
    assign I_Id     = act_id_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// Bench for interrupt_controller: directed reset/request steps, then random traffic
// checked against an edge-indexed behavioural model.
module tb_interrupt_controller;

    localparam int S = 2;
    localparam int H = 2;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic [1:0]  Irq_In = 2'b00;
    logic        IO_EnR = 1'b0;
    logic        IO_EnW = 1'b0;
    logic [31:0] IO_DataW = 32'd0;
    logic [31:0] IO_DataR;
    logic        I_Req;
    logic        I_Id;

    interrupt_controller #(.SYNC_STAGES(S), .HOLDOFF_CYCLES(H)) dut (
        .Clock(Clock), .Reset(Reset), .Irq_In(Irq_In),
        .IO_EnR(IO_EnR), .IO_EnW(IO_EnW), .IO_DataW(IO_DataW),
        .IO_DataR(IO_DataR), .I_Req(I_Req), .I_Id(I_Id)
    );

    always #5 Clock = ~Clock;

    int n_chk = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: irq samples indexed by edge; a rise lands S edges after its first sample,
    // and the grant time after an ACK is computed directly from the holdoff length.
    bit [1:0]  m_samp [S+1];
    bit [1:0]  m_pend, m_en, m_ovf;
    bit        m_active, m_id;
    bit [31:0] m_dr;
    int        m_t = 0;
    int        m_grant_at = 0;

    task automatic model_edge();
        bit [1:0]  rise, setm, ackm;
        bit [1:0]  pre_pend, pre_en;
        bit        ack_ok;
        m_t++;
        if (Reset) begin
            m_pend = 0; m_en = 0; m_ovf = 0; m_active = 0; m_id = 0; m_dr = 0;
            m_grant_at = 0;
            for (int i = 0; i <= S; i++) m_samp[i] = 2'b00;
            return;
        end
        rise = m_samp[S-1] & ~m_samp[S];
        for (int i = S; i > 0; i--) m_samp[i] = m_samp[i-1];
        m_samp[0] = Irq_In;

        pre_pend = m_pend;
        pre_en   = m_en;
        if (IO_EnR) m_dr = {24'd0, m_id, m_active, m_ovf, m_en, m_pend};

        ack_ok = IO_EnW && IO_DataW[31:30] == 2'b10 && m_active && IO_DataW[0] == m_id;
        ackm   = ack_ok ? (2'b01 << m_id) : 2'b00;
        setm   = rise & pre_en;
        m_pend = (pre_pend & ~ackm) | setm;
        if (IO_EnW && IO_DataW[31:30] == 2'b11) m_ovf = m_ovf & ~IO_DataW[5:4];
        m_ovf  = m_ovf | (setm & pre_pend & ~ackm);
        if (IO_EnW && IO_DataW[31:30] == 2'b01) m_en = IO_DataW[1:0];

        if (m_active && ack_ok) begin
            m_active   = 0;
            m_grant_at = m_t + H + 1;
        end else if (!m_active && m_t >= m_grant_at && (pre_pend & pre_en) != 0) begin
            m_active = 1;
            m_id     = (pre_pend[0] & pre_en[0]) ? 1'b0 : 1'b1;
        end
    endtask

    task automatic step(input bit rst, input bit rd, input bit wr, input logic [31:0] dw);
        Reset = rst; IO_EnR = rd; IO_EnW = wr; IO_DataW = dw;
        @(posedge Clock);
        model_edge();
        #1;
        check_val("i_req", {31'd0, I_Req}, {31'd0, m_active});
        if (m_active) check_val("i_id", {31'd0, I_Id}, {31'd0, m_id});
        check_val("io_datar", IO_DataR, m_dr);
    endtask

    initial begin
        for (int i = 0; i <= S; i++) m_samp[i] = 2'b00;

        // Reset and read-back
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        check_val("reset_i_id", {31'd0, I_Id}, 32'd0);
        step(0, 1, 0, 0);
        check_val("reset_read", IO_DataR, 32'h0000_0000);
        check_val("reset_req", {31'd0, I_Req}, 32'd0);

        // Basic request with latency, status read and ACK
        step(0, 0, 1, 32'h4000_0003);
        Irq_In = 2'b10;
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        check_val("req_not_early", {31'd0, I_Req}, 32'd0);
        step(0, 0, 0, 0);
        check_val("req_latency", {31'd0, I_Req}, 32'd1);
        check_val("req_id", {31'd0, I_Id}, 32'd1);
        step(0, 1, 0, 0);
        check_val("status_read", IO_DataR, 32'h0000_00CE);
        step(0, 0, 1, 32'h8000_0001);
        check_val("ack_drop", {31'd0, I_Req}, 32'd0);
        step(0, 1, 0, 0);
        check_val("ack_pend_clear", {30'd0, IO_DataR[1:0]}, 32'd0);
        Irq_In = 2'b00;

        // Random traffic
        for (int c = 0; c < 4000; c++) begin
            bit rst, rd, wr;
            logic [31:0] dw;
            for (int b = 0; b < 2; b++)
                if ($urandom_range(0, 5) == 0) Irq_In[b] = ~Irq_In[b];
            rst = ($urandom_range(0, 299) == 0);
            rd  = $urandom_range(0, 1);
            wr  = ($urandom_range(0, 3) == 0);
            dw  = $urandom;
            if (wr && dw[31:30] == 2'b10 && $urandom_range(0, 1) == 1) dw[0] = m_id;
            if (wr && dw[31:30] == 2'b01 && $urandom_range(0, 3) != 0) dw[1:0] = 2'b11;
            step(rst, rd, wr, dw);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/interrupt_controller.md
# interrupt_controller

- External interrupt controller for the pipelined Beta core. It sits directly upstream of the core's interrupt inputs and drives `EIC_I_Req` / `EIC_I_Id`.
- It synchronizes two asynchronous interrupt lines, edge-detects them, and latches them as pending. It arbitrates by fixed priority and holds one request toward the core until the handler acknowledges it.
- Software programs it over the core's single-port IO channel (`IO_EnR`/`IO_EnW`/`IO_DataW`/`IO_DataR`).

## Interface
Parameters:
- `SYNC_STAGES`, default 2: flip-flops in each input synchronizer (≥2).
- `HOLDOFF_CYCLES`, default 2: cycles `I_Req` stays low after an acknowledge before a new request may assert (≥1).

Ports:
- `Clock`  in  1: system clock; all state is updated on its rising edge.
- `Reset`  in  1: synchronous, active-high reset.
- `Irq_In`  in  2: asynchronous external interrupt lines; `[0]` has the higher priority.
- `IO_EnR`  in  1: IO read strobe from the core (MA stage).
- `IO_EnW`  in  1: IO write strobe from the core (MA stage).
- `IO_DataW`  in  32: IO write data (command word).
- `IO_DataR`  out  32: registered status word.
- `I_Req`  out  1: interrupt request to the core (`EIC_I_Req`); registered.
- `I_Id`  out  1: id of the requesting source (`EIC_I_Id`); registered; stable while `I_Req`=1.

## Operation
- **Input synchronization.** Each `Irq_In` bit passes through `SYNC_STAGES` flops and then one history flop. `Rise[i]` = synced & ~history.
- **Enable mask `En[1:0]`.** `Rise[i]` with `En[i]`=1 sets `Pend[i]`. `Rise[i]` with `En[i]`=0 is discarded. Clearing `En[i]` does not clear `Pend[i]`; it only makes source i ineligible.
- **Overflow `Ovf[i]`.** Set when `Rise[i]` && `En[i]` && `Pend[i]` is already 1. Sticky.
- **Eligibility and priority.**
  - `Elig` = `Pend & En`.
  - The winner is the lowest eligible index.
- **FSM states:** IDLE, ACTIVE, HOLDOFF.
  - **IDLE:** if `Elig`≠0, latch the winner into `ActId` and go to ACTIVE.
  - **ACTIVE:** `I_Req`=1 and `I_Id`=`ActId`.
    - An ACK command with id == `ActId` clears `Pend[ActId]`, loads the holdoff counter with `HOLDOFF_CYCLES`-1 and goes to HOLDOFF.
    - An ACK with a different id is ignored.
    - A mask change does not withdraw the active request.
  - **HOLDOFF:** `I_Req`=0. The counter decrements each cycle; at 0 the FSM goes to IDLE.
  - ACK commands in IDLE or HOLDOFF are ignored.
- **Write command** (`IO_EnW`=1), decoded from `IO_DataW[31:30]`:
  - `00`: NOP.
  - `01`: `En` ← `IO_DataW[1:0]`.
  - `10`: ACK, id = `IO_DataW[0]`.
  - `11`: `Ovf` ← `Ovf` & ~`IO_DataW[5:4]` (write-1-to-clear).
- **Simultaneous ACK and new rise on the same source:** the set wins. `Pend` stays 1 and `Ovf` is not set.
- **Read** (`IO_EnR`=1): `IO_DataR` is loaded at the clock edge and held until the next read.
  - `[1:0]` `Pend`
  - `[3:2]` `En`
  - `[5:4]` `Ovf`
  - `[6]` ACTIVE
  - `[7]` `ActId`
  - `[31:8]` 0
  - The loaded value reflects state before that edge's updates.
- **Simultaneous `IO_EnR` and `IO_EnW`:** both are performed. The read returns pre-write state.

## Timing
- **Reset values:** `I_Req`=0, `I_Id`=0, `IO_DataR`=0, `Pend`=0, `En`=0, `Ovf`=0, FSM=IDLE, all synchronizer and history flops 0.
  - Reset overrides everything, including mid-request: `I_Req` drops the cycle after Reset is sampled.
- **Interrupt latency:** with `Irq_In[i]` first sampled high at edge k:
  - `Pend[i]` = 1 after edge k+`SYNC_STAGES`.
  - `I_Req` = 1 after edge k+`SYNC_STAGES`+1.
  - For the default, that is 3 edges.
- **ACK to request low:** an ACK write sampled at edge a gives `I_Req`=0 after edge a.
  - With `Elig` still ≠0, `I_Req` re-asserts after edge a+`HOLDOFF_CYCLES`+1.
- **Read latency:** `IO_DataR` is valid after the edge that samples `IO_EnR`. This matches the core's WB capture.
- **Level-held inputs** produce exactly one rise. A new rise needs the line to go low for at least one synced cycle.

## Test plan
1. **Reset and read-back.** Hold Reset 2 cycles, then read (`IO_EnR`) → `IO_DataR`=0x00000000, `I_Req`=0.
2. **Basic request and ACK.** Write 0x40000003 (enable both). Raise `Irq_In[1]` → `I_Req`=1 and `I_Id`=1 three edges after first sample. Read → 0x000000CE. Write 0x80000001 → `I_Req`=0 next cycle and `Pend`=00.
3. **Priority and re-assert.** With both enabled, raise `Irq_In[1]` then `Irq_In[0]` while source 1 is ACTIVE → `I_Id` stays 1. ACK id 1 → `I_Req` low for 2 cycles, then `I_Req`=1 with `I_Id`=0.
4. **Masked source.** Write 0x40000001, raise `Irq_In[1]` → `Pend[1]` stays 0 and `I_Req` stays 0. Enabling source 1 afterwards still produces no request.
5. **Overflow and clear.** With source 0 pending, pulse `Irq_In[0]` again → `Ovf[0]`=1 (read bit 4). Write 0xC0000010 → read shows bit 4 = 0. A wrong-id ACK (0x80000001 while `ActId`=0) → no change.
6. **Reset mid-operation.** Assert Reset while ACTIVE → after one edge `I_Req`=0, `En`=0, `Pend`=0. Deassert with `Irq_In` already high → no request, because `En`=0.
